// File: rtl/riscv_pkg.sv
// riscv_pkg: shared register-file sizing constants and the register address type
package riscv_pkg;
  localparam int XLEN = 32;
  localparam int NUM_REGS = 32;
  localparam int REG_ADDR_W = $clog2(NUM_REGS);
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-register pending bits (issue sets, writeback clears, flush wipes; set beats clear) with two busy lookups
module reg_scoreboard import riscv_pkg::*; #(
  parameter int NUM_REGS = riscv_pkg::NUM_REGS
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      in_set,
  input  reg_addr_t in_set_rd,
  input  logic      in_clr,
  input  reg_addr_t in_clr_rd,
  input  logic      in_flush,
  input  reg_addr_t in_rs1,
  input  reg_addr_t in_rs2,
  output logic      out_rs1_busy,
  output logic      out_rs2_busy
);
  logic [NUM_REGS-1:0] pending, set_mask, clr_mask;
  always_comb begin
    set_mask = in_set ? NUM_REGS'(1) << in_set_rd : '0;
    clr_mask = in_clr ? NUM_REGS'(1) << in_clr_rd : '0;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) pending <= '0;
    else pending <= in_flush ? '0 : (pending & ~clr_mask) | set_mask;
  assign out_rs1_busy = pending[in_rs1];
  assign out_rs2_busy = pending[in_rs2];
endmodule

// File: rtl/register_file.sv
// register_file: 2R/1W register file, x0 hardwired 0, async active-low reset, pending scoreboard; REGFILE_BYPASS_EN forwards same-cycle writeback to reads
module register_file import riscv_pkg::*; #(
  parameter int              XLEN     = riscv_pkg::XLEN,
  parameter int              NUM_REGS = riscv_pkg::NUM_REGS,
  parameter logic [XLEN-1:0] SP_RESET = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  reg_addr_t       in_rs1,
  input  reg_addr_t       in_rs2,
  output logic [XLEN-1:0] out_rs1_data,
  output logic [XLEN-1:0] out_rs2_data,
  output logic            out_rs1_busy,
  output logic            out_rs2_busy,
  input  logic [XLEN-1:0] in_wb_data,
  input  reg_addr_t       in_wb_rd,
  input  logic            in_wb_write_enable,
  input  logic            in_issue_valid,
  input  reg_addr_t       in_issue_rd,
  input  logic            in_issue_rd_write,
  input  logic            in_flush
);
  logic [XLEN-1:0] regs [NUM_REGS];
  logic wb_we, issue_set, sb_busy1, sb_busy2, hit1, hit2;
  assign wb_we = in_wb_write_enable && in_wb_rd != '0;
  assign issue_set = in_issue_valid && in_issue_rd_write && in_issue_rd != '0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) for (int i = 0; i < NUM_REGS; i++) regs[i] <= (i == 2) ? SP_RESET : '0;
    else if (wb_we) regs[in_wb_rd] <= in_wb_data;
  reg_scoreboard #(.NUM_REGS(NUM_REGS)) u_sb (
    .clk(clk), .reset(reset),
    .in_set(issue_set), .in_set_rd(in_issue_rd),
    .in_clr(wb_we), .in_clr_rd(in_wb_rd),
    .in_flush(in_flush),
    .in_rs1(in_rs1), .in_rs2(in_rs2),
    .out_rs1_busy(sb_busy1), .out_rs2_busy(sb_busy2)
  );
`ifdef REGFILE_BYPASS_EN
  assign hit1 = wb_we && in_wb_rd == in_rs1;
  assign hit2 = wb_we && in_wb_rd == in_rs2;
`else
  assign hit1 = 1'b0;
  assign hit2 = 1'b0;
`endif
  always_comb begin
    out_rs1_data = hit1 ? in_wb_data : regs[in_rs1];
    out_rs2_data = hit2 ? in_wb_data : regs[in_rs2];
    out_rs1_busy = hit1 ? issue_set && !in_flush && in_issue_rd == in_rs1 : sb_busy1;
    out_rs2_busy = hit2 ? issue_set && !in_flush && in_issue_rd == in_rs2 : sb_busy2;
  end
endmodule
